// File: rtl/microwave_timer_ctrl.sv
// microwave_timer_ctrl: keypad entry, load, 1 Hz-gated countdown and beep sequencing for a BCD MM:SS timer
// Ports: clk/clrn (async active-low reset); key_valid/key_digit keypad strobe and BCD digit;
//   start, stop_clear strobes; door_closed level; cnt_zero from counter chain;
//   load_data/cnt_loadn/cnt_en drive the counter chain; magnetron_on, done_beep, state (debug).
module microwave_timer_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int BEEP_TICKS = 3
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  input  logic        cnt_zero,
  output logic [15:0] load_data,
  output logic        cnt_loadn,
  output logic        cnt_en,
  output logic        magnetron_on,
  output logic        done_beep,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5,
    CLR   = 3'd6
  } state_t;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = BEEP_TICKS > 1 ? $clog2(BEEP_TICKS) : 1;
  state_t st;
  logic [15:0] entry;
  logic [PW-1:0] presc;
  logic [BW-1:0] beep;
  logic tick, key_ok, start_ok;
  assign tick     = presc == PW'(TICK_DIV - 1);
  assign key_ok   = key_valid && key_digit <= 4'd9;
  assign start_ok = start && door_closed && entry != 16'h0000 && entry[7:4] <= 4'd5;
  // Prescaler and beep counter default to zero so every entry into COOK or DONE starts a fresh tick period.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      st    <= IDLE;
      entry <= '0;
      presc <= '0;
      beep  <= '0;
    end else begin
      presc <= '0;
      beep  <= '0;
      case (st)
        IDLE:
          if (stop_clear) st <= CLR;
          else if (key_ok) begin
            st    <= ENTRY;
            entry <= {entry[11:0], key_digit};
          end
        ENTRY:
          if (stop_clear) st <= CLR;
          else if (start_ok) st <= LOAD;
          else if (key_ok) entry <= {entry[11:0], key_digit};
        LOAD: begin
          st    <= COOK;
          entry <= '0;
        end
        COOK:
          if (stop_clear || !door_closed) st <= PAUSE;
          else if (cnt_zero) st <= DONE;
          else presc <= tick ? '0 : presc + 1'b1;
        PAUSE:
          if (stop_clear) st <= CLR;
          else if (start && door_closed) st <= COOK;
        DONE:
          if (stop_clear || !door_closed || (tick && beep == BW'(BEEP_TICKS - 1))) st <= IDLE;
          else begin
            presc <= tick ? '0 : presc + 1'b1;
            beep  <= tick ? beep + 1'b1 : beep;
          end
        CLR: begin
          st    <= IDLE;
          entry <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  end
  // cnt_en is the only output with a combinational input dependency (cnt_zero).
  assign load_data    = st == LOAD ? entry : 16'h0000;
  assign cnt_loadn    = !(st == LOAD || st == CLR);
  assign cnt_en       = st == COOK && tick && !cnt_zero;
  assign magnetron_on = st == COOK;
  assign done_beep    = st == DONE;
  assign state        = st;
endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// tb_microwave_timer_ctrl: vector table, directed corner cases and random run against a reference model
module tb_microwave_timer_ctrl;
  localparam int TD = 4;
  localparam int BT = 3;
  logic clk = 0, clrn = 0, key_valid = 0, start = 0, stop_clear = 0, door_closed = 1, cnt_zero = 0;
  logic [3:0] key_digit = 0;
  logic [15:0] load_data;
  logic cnt_loadn, cnt_en, magnetron_on, done_beep;
  logic [2:0] state;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  microwave_timer_ctrl #(.TICK_DIV(TD), .BEEP_TICKS(BT)) dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit), .start(start),
    .stop_clear(stop_clear), .door_closed(door_closed), .cnt_zero(cnt_zero), .load_data(load_data),
    .cnt_loadn(cnt_loadn), .cnt_en(cnt_en), .magnetron_on(magnetron_on), .done_beep(done_beep), .state(state)
  );
  typedef struct {
    logic kv;
    logic [3:0] kd;
    logic st, sc, dc, cz;
    logic [2:0] es;
    logic [15:0] eld;
    logic een;
  } vec_t;
  vec_t vq[$];
  function automatic void add(input logic kv, input logic [3:0] kd, input logic st, sc, dc, cz,
                              input logic [2:0] es, input logic [15:0] eld, input logic een);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sc = sc; v.dc = dc; v.cz = cz; v.es = es; v.eld = eld; v.een = een;
    vq.push_back(v);
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Outputs other than load_data/cnt_en follow directly from the expected state code.
  task automatic check_all(input string tag, input logic [2:0] es, input logic [15:0] eld, input logic een);
    chk({tag, " state"}, 16'(state), 16'(es));
    chk({tag, " load_data"}, load_data, eld);
    chk({tag, " cnt_loadn"}, 16'(cnt_loadn), 16'(!(es == 3'd2 || es == 3'd6)));
    chk({tag, " cnt_en"}, 16'(cnt_en), 16'(een));
    chk({tag, " magnetron_on"}, 16'(magnetron_on), 16'(es == 3'd3));
    chk({tag, " done_beep"}, 16'(done_beep), 16'(es == 3'd5));
  endtask
  task automatic drive(input logic kv, input logic [3:0] kd, input logic st, sc, dc, cz);
    key_valid = kv; key_digit = kd; start = st; stop_clear = sc; door_closed = dc; cnt_zero = cz;
  endtask
  // Reference model: mode codes, keypad digits as a queue, cycle counts within COOK and DONE.
  int m_mode, m_cc, m_dc;
  int m_dig[$];
  function automatic int m_entry();
    int v = 0;
    foreach (m_dig[i]) v = v * 16 + m_dig[i];
    return v;
  endfunction
  function automatic void m_key();
    if (key_valid && key_digit <= 9) begin
      m_dig.push_back(int'(key_digit));
      if (m_dig.size() > 4) void'(m_dig.pop_front());
    end
  endfunction
  function automatic void m_step();
    int v = m_entry();
    case (m_mode)
      0: if (stop_clear) m_mode = 6; else if (key_valid && key_digit <= 9) begin m_key(); m_mode = 1; end
      1: if (stop_clear) m_mode = 6;
         else if (start && door_closed && v != 0 && (v / 16) % 16 <= 5) m_mode = 2;
         else m_key();
      2: begin m_dig.delete(); m_mode = 3; m_cc = 0; end
      3: if (stop_clear || !door_closed) m_mode = 4;
         else if (cnt_zero) begin m_mode = 5; m_dc = 0; end
         else m_cc++;
      4: if (stop_clear) m_mode = 6; else if (start && door_closed) begin m_mode = 3; m_cc = 0; end
      5: if (stop_clear || !door_closed || m_dc == BT * TD - 1) m_mode = 0; else m_dc++;
      default: begin m_dig.delete(); m_mode = 0; end
    endcase
  endfunction
  initial begin
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0, 0, 0);
    add(1, 3, 0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 2, 16'h0130, 0);
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) add(0, 0, 0, 0, 1, 0, 3, 0, 0);
      add(0, 0, 0, 0, 1, 0, 3, 0, 1);
    end
    for (int j = 0; j < 3; j++) add(0, 0, 0, 0, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 1, 1, 3, 0, 0);
    for (int j = 0; j < BT * TD; j++) add(0, 0, 0, 0, 1, 0, 5, 0, 0);
    add(1, 7, 0, 0, 1, 0, 0, 0, 0);
    add(1, 5, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0);
    add(1, 4'hC, 0, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 2, 16'h0751, 0);
    add(0, 0, 0, 0, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 1, 0, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 1, 0, 1, 0, 4, 0, 0);
    for (int j = 0; j < 3; j++) add(0, 0, 0, 0, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 1, 0, 3, 0, 1);
    add(0, 0, 0, 1, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 1, 0, 4, 0, 0);
    add(0, 0, 1, 1, 1, 0, 4, 0, 0);
    add(0, 0, 0, 0, 1, 0, 6, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0);
    add(1, 2, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 2, 16'h0002, 0);
    add(0, 0, 0, 0, 1, 0, 3, 0, 0);
    #1;
    check_all("reset", 0, 0, 0);
    @(negedge clk);
    clrn = 1;
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].kv, vq[i].kd, vq[i].st, vq[i].sc, vq[i].dc, vq[i].cz);
      #1;
      check_all($sformatf("vec%0d", i), vq[i].es, vq[i].eld, vq[i].een);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0);
    #1;
    chk("cook before reset", 16'(state), 16'd3);
    #2 clrn = 0;
    #1;
    check_all("async reset", 0, 0, 0);
    @(negedge clk);
    clrn = 1;
    drive(1, 1, 0, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0);
    #1;
    check_all("post reset load", 2, 16'h0001, 0);
    @(negedge clk);
    clrn = 0;
    @(negedge clk);
    clrn = 1;
    m_mode = 0; m_cc = 0; m_dc = 0; m_dig.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      key_valid = $urandom_range(0, 2) == 0;
      key_digit = 4'($urandom_range(0, 15));
      start = $urandom_range(0, 5) == 0;
      stop_clear = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 29) == 0) door_closed = !door_closed;
      cnt_zero = $urandom_range(0, 24) == 0;
      #1;
      check_all($sformatf("rnd%0d", c), 3'(m_mode), m_mode == 2 ? 16'(m_entry()) : 16'h0000,
                m_mode == 3 && m_cc % TD == TD - 1 && !cnt_zero);
      m_step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
